// File: rtl/board_mem_arbiter_pkg.sv
// Board RAM geometry, piece codes, arbiter FSM states and the chess start-position lookup.
// Pure declarations and combinational helpers; no state.
package board_mem_arbiter_pkg;

  localparam int N_REQ    = 4;
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 4;
  localparam int RAM_LAT  = 1;
  localparam int ID_W     = $clog2(N_REQ);
  localparam int PIPE_D   = RAM_LAT + 1;
  localparam int BOARD_SQ = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] piece_t;
  typedef logic [ID_W-1:0]   req_id_t;

  localparam piece_t P_EMPTY  = 4'd0;
  localparam piece_t B_PAWN   = 4'd1;
  localparam piece_t B_KNIGHT = 4'd2;
  localparam piece_t B_BISHOP = 4'd3;
  localparam piece_t B_ROOK   = 4'd4;
  localparam piece_t B_QUEEN  = 4'd5;
  localparam piece_t B_KING   = 4'd6;
  localparam piece_t W_PAWN   = 4'd7;
  localparam piece_t W_KNIGHT = 4'd8;
  localparam piece_t W_BISHOP = 4'd9;
  localparam piece_t W_ROOK   = 4'd10;
  localparam piece_t W_QUEEN  = 4'd11;
  localparam piece_t W_KING   = 4'd12;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // One slot of the read-return pipeline: which requester the RAM output belongs to.
  typedef struct packed {
    logic    vld;
    req_id_t id;
  } rd_tag_t;

  function automatic piece_t back_rank(input logic [2:0] x, input logic white);
    piece_t p;
    case (x)
      3'd0, 3'd7: p = white ? W_ROOK   : B_ROOK;
      3'd1, 3'd6: p = white ? W_KNIGHT : B_KNIGHT;
      3'd2, 3'd5: p = white ? W_BISHOP : B_BISHOP;
      3'd3:       p = white ? W_QUEEN  : B_QUEEN;
      default:    p = white ? W_KING   : B_KING;
    endcase
    return p;
  endfunction

  // Square address is y*8 + x: the upper three bits select the rank.
  function automatic piece_t start_piece(input addr_t a);
    piece_t p;
    case (a[ADDR_W-1:3])
      3'd0:    p = back_rank(a[2:0], 1'b0);
      3'd1:    p = B_PAWN;
      3'd6:    p = W_PAWN;
      3'd7:    p = back_rank(a[2:0], 1'b1);
      default: p = P_EMPTY;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/board_mem_arbiter_if.sv
// Requester-side bus of the board RAM arbiter: packed per-requester request fields plus shared read return.
interface board_mem_arbiter_if;
  import board_mem_arbiter_pkg::*;

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        we;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  piece_t                  rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/board_mem_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or after the pointer, wrapping.
module board_mem_arbiter_rr
  import board_mem_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  req_id_t          i_ptr,
  output logic [N_REQ-1:0] o_gnt_onehot,
  output req_id_t          o_winner,
  output logic             o_found
);

  req_id_t w_idx;

  // Scan from the farthest offset down so the nearest request after the pointer wins last.
  always_comb begin
    o_gnt_onehot = '0;
    o_winner     = '0;
    o_found      = 1'b0;
    w_idx        = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = i_ptr + req_id_t'(k);
      if (i_req[w_idx]) begin
        o_winner = w_idx;
        o_found  = 1'b1;
      end
    end
    if (o_found) begin
      o_gnt_onehot[o_winner] = 1'b1;
    end
  end

endmodule

// File: rtl/board_mem_arbiter.sv
// Shares the single-port 64x4 board RAM among four requesters and loads the start position.
// Grant and RAM command are registered together; reads return RAM_LAT+1 cycles after grant; losers just wait.
module board_mem_arbiter
  import board_mem_arbiter_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_init_req,
  board_mem_arbiter_if.slave io_bus,
  output logic               o_init_done,
  output addr_t              o_ram_addr,
  output piece_t             o_ram_wdata,
  output logic               o_ram_we,
  input  piece_t             i_ram_q
);

  state_t           r_state;
  state_t           w_state_nxt;
  addr_t            r_cnt;
  addr_t            w_cnt_nxt;
  req_id_t          r_ptr;
  req_id_t          w_ptr_nxt;

  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic             r_ram_we;
  logic             w_ram_we_nxt;
  addr_t            r_ram_addr;
  addr_t            w_ram_addr_nxt;
  piece_t           r_ram_wdata;
  piece_t           w_ram_wdata_nxt;

  rd_tag_t          r_pipe [PIPE_D];
  rd_tag_t          w_rd_tag;
  logic             w_pipe_busy;
  logic [N_REQ-1:0] r_rvalid;
  piece_t           r_rdata;

  logic [N_REQ-1:0] w_arb_gnt;
  req_id_t          w_arb_idx;
  logic             w_arb_found;
  addr_t            w_sel_addr;
  piece_t           w_sel_wdata;

  board_mem_arbiter_rr u_rr (
    .i_req        (io_bus.req),
    .i_ptr        (r_ptr),
    .o_gnt_onehot (w_arb_gnt),
    .o_winner     (w_arb_idx),
    .o_found      (w_arb_found)
  );

  assign w_sel_addr  = io_bus.addr[int'(w_arb_idx) * ADDR_W +: ADDR_W];
  assign w_sel_wdata = io_bus.wdata[int'(w_arb_idx) * DATA_W +: DATA_W];

  always_comb begin
    w_pipe_busy = 1'b0;
    for (int i = 0; i < PIPE_D; i++) begin
      w_pipe_busy = w_pipe_busy | r_pipe[i].vld;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Address/wdata hold their last value when idle; only ram_we qualifies a write.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_ptr_nxt       = r_ptr;
    w_gnt_nxt       = '0;
    w_ram_we_nxt    = 1'b0;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_wdata_nxt = r_ram_wdata;
    w_rd_tag        = '0;
    unique case (r_state)
      ST_INIT: begin
        w_ram_we_nxt    = 1'b1;
        w_ram_addr_nxt  = r_cnt;
        w_ram_wdata_nxt = start_piece(r_cnt);
        w_cnt_nxt       = r_cnt + addr_t'(1);
        if (r_cnt == addr_t'(BOARD_SQ - 1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_arb_found) begin
          w_gnt_nxt       = w_arb_gnt;
          w_ram_we_nxt    = io_bus.we[w_arb_idx];
          w_ram_addr_nxt  = w_sel_addr;
          w_ram_wdata_nxt = w_sel_wdata;
          w_rd_tag.vld    = ~io_bus.we[w_arb_idx];
          w_rd_tag.id     = w_arb_idx;
          // A locked winner keeps the pointer so it wins again next cycle.
          w_ptr_nxt       = io_bus.lock[w_arb_idx] ? w_arb_idx : w_arb_idx + req_id_t'(1);
        end
        if (i_init_req) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!w_pipe_busy) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rvalid    <= '0;
      r_rdata     <= '0;
      for (int i = 0; i < PIPE_D; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_ram_we    <= w_ram_we_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_pipe[0]   <= w_rd_tag;
      for (int i = 1; i < PIPE_D; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
      // The last tag lines up with the cycle the RAM output is valid.
      r_rvalid <= '0;
      if (r_pipe[PIPE_D-1].vld) begin
        r_rvalid[r_pipe[PIPE_D-1].id] <= 1'b1;
        r_rdata                       <= i_ram_q;
      end
    end
  end

  assign io_bus.gnt    = r_gnt;
  assign io_bus.rvalid = r_rvalid;
  assign io_bus.rdata  = r_rdata;
  assign o_ram_we      = r_ram_we;
  assign o_ram_addr    = r_ram_addr;
  assign o_ram_wdata   = r_ram_wdata;
  assign o_init_done   = (r_state == ST_RUN);

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter: behavioural board/queue model checked every cycle plus literal pins.
module tb_board_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_req = 1'b0;
  logic [5:0] ram_addr;
  logic [3:0] ram_wdata;
  logic [3:0] ram_q;
  logic ram_we;
  logic init_done;

  board_mem_arbiter_if bus();

  board_mem_arbiter dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_init_req  (init_req),
    .io_bus      (bus),
    .o_init_done (init_done),
    .o_ram_addr  (ram_addr),
    .o_ram_wdata (ram_wdata),
    .o_ram_we    (ram_we),
    .i_ram_q     (ram_q)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, one cycle read latency, old data on collision.
  logic [3:0] ram [64];
  always @(posedge clk) begin
    if (ram_we === 1'b1) ram[ram_addr] <= ram_wdata;
    ram_q <= ram[ram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Start position written out by rank, x=0 in the lowest nibble.
  function automatic logic [3:0] exp_start(input int a);
    logic [31:0] row0;
    logic [31:0] row7;
    int x;
    int y;
    row0 = 32'h42365324;
    row7 = 32'hA89CB98A;
    x = a % 8;
    y = a / 8;
    if (y == 0) return row0[x*4 +: 4];
    if (y == 7) return row7[x*4 +: 4];
    if (y == 1) return 4'd1;
    if (y == 6) return 4'd7;
    return 4'd0;
  endfunction

  // Model: mode 0 loading, 1 serving, 2 waiting for outstanding reads.
  typedef struct {
    int         due;
    int         id;
    logic [3:0] d;
  } pend_t;
  pend_t      pend [$];
  int         cyc = 0;
  int         m_mode = 0;
  int         m_cnt = 0;
  int         m_ptr = 0;
  bit         m_on = 1'b0;
  logic [3:0] m_board [64];
  logic [3:0] e_gnt = '0;
  logic [3:0] e_rv = '0;
  logic [3:0] e_rdata = '0;
  logic [3:0] e_wdata = '0;
  logic [5:0] e_addr = '0;
  logic       e_we = 1'b0;
  logic       e_done = 1'b0;

  initial begin : model
    pend_t p;
    int    w;
    int    c;
    bit    empty0;
    for (int i = 0; i < 64; i++) m_board[i] = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_on = 1'b1; m_mode = 0; m_cnt = 0; m_ptr = 0;
        pend.delete();
        e_gnt = '0; e_rv = '0; e_rdata = '0; e_wdata = '0;
        e_addr = '0; e_we = 1'b0; e_done = 1'b0;
      end else if (m_on) begin
        empty0 = (pend.size() == 0);
        e_rv = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
          p = pend.pop_front();
          e_rv[p.id] = 1'b1;
          e_rdata = p.d;
        end
        e_gnt = '0;
        e_we = 1'b0;
        if (m_mode == 0) begin
          e_we = 1'b1;
          e_addr = 6'(m_cnt);
          e_wdata = exp_start(m_cnt);
          m_board[m_cnt] = e_wdata;
          if (m_cnt == 63) m_mode = 1;
          m_cnt = (m_cnt + 1) % 64;
        end else if (m_mode == 1) begin
          w = -1;
          for (int k = 0; k < 4; k++) begin
            c = (m_ptr + k) % 4;
            if (w < 0 && bus.req[c]) w = c;
          end
          if (w >= 0) begin
            e_gnt[w] = 1'b1;
            e_we = bus.we[w];
            e_addr = bus.addr[w*6 +: 6];
            e_wdata = bus.wdata[w*4 +: 4];
            if (bus.we[w]) begin
              m_board[e_addr] = e_wdata;
            end else begin
              p.due = cyc + 2; p.id = w; p.d = m_board[e_addr];
              pend.push_back(p);
            end
            m_ptr = bus.lock[w] ? w : (w + 1) % 4;
          end
          if (init_req) m_mode = 2;
        end else begin
          if (empty0) begin
            m_mode = 0;
            m_cnt = 0;
          end
        end
        e_done = (m_mode == 1);
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (m_on) begin
        chk("gnt", 32'(bus.gnt), 32'(e_gnt));
        chk("rvalid", 32'(bus.rvalid), 32'(e_rv));
        if (e_rv != 0) chk("rdata", 32'(bus.rdata), 32'(e_rdata));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        if (e_we || e_gnt != 0) chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        if (e_we) chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
        chk("init_done", 32'(init_done), 32'(e_done));
      end
    end
  end

  logic [3:0] gh [10];
  logic [3:0] rvh [10];
  logic [3:0] rdh [10];
  int nwr, ngnt, nrv, found, rvj, dj;
  bit seen;
  logic [3:0] rd;

  initial begin : stim
    bus.req = '0; bus.we = '0; bus.lock = '0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    rst = 1'b0;

    // Power-up load.
    nwr = 0; ngnt = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (ram_we) nwr++;
      if (bus.gnt != 0) ngnt++;
      if (init_done) seen = 1'b1;
    end
    chk("t1_done_seen", 32'(seen), 32'd1);
    chk("t1_writes", nwr, 64);
    chk("t1_no_gnt", ngnt, 0);
    @(negedge clk);
    chk("t1_sq4", 32'(ram[4]), 32'd6);
    chk("t1_sq60", 32'(ram[60]), 32'd12);
    chk("t1_sq20", 32'(ram[20]), 32'd0);

    // All four reading continuously.
    bus.req = 4'hF;
    bus.addr = {6'd57, 6'd8, 6'd1, 6'd0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      gh[i] = bus.gnt; rvh[i] = bus.rvalid; rdh[i] = bus.rdata;
      if (i == 7) bus.req = '0;
    end
    chk("t2_g0", 32'(gh[0]), 32'd1);
    chk("t2_g1", 32'(gh[1]), 32'd2);
    chk("t2_g2", 32'(gh[2]), 32'd4);
    chk("t2_g3", 32'(gh[3]), 32'd8);
    chk("t2_g4", 32'(gh[4]), 32'd1);
    chk("t2_rv0", 32'(rvh[2]), 32'd1);
    chk("t2_rd0", 32'(rdh[2]), 32'd4);
    chk("t2_rd1", 32'(rdh[3]), 32'd2);
    chk("t2_rd3", 32'(rdh[5]), 32'd8);
    chk("t2_rv_last", 32'(rvh[9]), 32'd8);

    // Idle, then a lone request from 3.
    ngnt = 0; nwr = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.gnt != 0) ngnt++;
      if (ram_we) nwr++;
    end
    chk("t6_idle_gnt", ngnt, 0);
    chk("t6_idle_we", nwr, 0);
    bus.req = 4'b1000; bus.addr = {6'd5, 18'd0};
    @(negedge clk);
    chk("t6_gnt3", 32'(bus.gnt), 32'd8);
    bus.req = '0;
    repeat (3) @(negedge clk);

    // Locked write-then-read by requester 0 against full contention.
    bus.req = 4'hF; bus.we = 4'b0001; bus.lock = 4'b0001;
    bus.addr = {6'd63, 6'd62, 6'd9, 6'd35};
    bus.wdata = {4'd0, 4'd0, 4'd0, 4'd1};
    @(negedge clk);
    chk("t3_gnt_wr", 32'(bus.gnt), 32'd1);
    bus.we = '0;
    @(negedge clk);
    chk("t3_gnt_rd", 32'(bus.gnt), 32'd1);
    bus.req = 4'b1110; bus.lock = '0;
    found = 0; rd = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rvalid[0]) begin found++; rd = bus.rdata; end
    end
    chk("t3_rv_seen", found, 1);
    chk("t3_rd35", 32'(rd), 32'd1);
    bus.req = '0;
    repeat (4) @(negedge clk);

    // Read of 63 coinciding with a reload request.
    bus.req = 4'b0100; bus.addr = {6'd0, 6'd63, 12'd0}; init_req = 1'b1;
    @(negedge clk);
    chk("t4_gnt2", 32'(bus.gnt), 32'd4);
    chk("t4_done_low", 32'(init_done), 32'd0);
    init_req = 1'b0; bus.req = '0;
    found = 0; nwr = 0; seen = 1'b0; rvj = 0; dj = 0; rd = '0;
    for (int j = 1; j <= 200 && !seen; j++) begin
      @(negedge clk);
      if (bus.rvalid[2]) begin found++; rd = bus.rdata; rvj = j; end
      if (ram_we) nwr++;
      if (init_done) begin seen = 1'b1; dj = j; end
    end
    chk("t4_rv_seen", found, 1);
    chk("t4_rd63", 32'(rd), 32'd10);
    chk("t4_rv_lat", rvj, 2);
    chk("t4_writes", nwr, 64);
    chk("t4_done_at", dj, 67);
    @(negedge clk);

    // Reset right after a read grant.
    bus.req = 4'b0001; bus.addr = {18'd0, 6'd4};
    @(negedge clk);
    chk("t5_gnt0", 32'(bus.gnt), 32'd1);
    rst = 1'b1; bus.req = '0;
    nrv = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rvalid != 0) nrv++;
    end
    rst = 1'b0;
    @(negedge clk);
    if (bus.rvalid != 0) nrv++;
    chk("t5_init_we", 32'(ram_we), 32'd1);
    chk("t5_init_addr0", 32'(ram_addr), 32'd0);
    repeat (4) begin
      @(negedge clk);
      if (bus.rvalid != 0) nrv++;
    end
    chk("t5_no_rvalid", nrv, 0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (init_done) seen = 1'b1;
    end
    chk("t5_reinit_done", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
